// File: rtl/shared_pkg.sv
// shared_pkg: FIFO geometry and read-side controller state encoding shared across the FIFO blocks
package shared_pkg;
  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;
  typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_STOP} rd_state_e;
endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry in-order buffer; head is entry 0, tail holds the second word
module fifo_reader_skid #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         write,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [1:0]   occ,
  output logic         overrun
);
  logic [W-1:0] tail;
  logic accept;
  assign overrun = write & (occ == 2'd2);
  assign accept = write & ~(overrun & ~pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= pop ? ((occ == 2'd2) ? tail : wdata) : (write && occ == 2'd0) ? wdata : head;
      if (accept && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) tail <= wdata;
      occ <= occ + 2'(accept) - 2'(pop);
    end
  end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops the synchronous FIFO, absorbs its read latency and streams words out via a skid buffer
module fifo_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  empty,
  input  logic                  underflow,
  input  logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy,
  output logic                  err
);
  import shared_pkg::*;
  rd_state_e state;
  logic infl, pop, overrun;
  logic [1:0] occ;
  assign pop = m_valid & m_ready;
  assign m_valid = occ != 2'd0;
  assign busy = state != RD_IDLE;
  // words already committed after this edge must never exceed the buffer depth
  assign rd_en = (state == RD_RUN) & enable & ~empty & (({1'b0, occ} + 3'(infl) - 3'(pop)) < 3'd2);
  fifo_reader_skid #(.W(FIFO_WIDTH)) skid (
    .clk(clk), .rst(rst), .write(infl), .pop(pop), .wdata(data_out),
    .head(m_data), .occ(occ), .overrun(overrun)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RD_IDLE;
      infl     <= 1'b0;
      rd_count <= '0;
      err      <= 1'b0;
    end else begin
      infl     <= rd_en;
      rd_count <= rd_count + CNT_WIDTH'(pop);
      err      <= err | underflow | overrun;
      state    <= (state == RD_IDLE) ? (enable ? RD_RUN : RD_IDLE) :
                  (state == RD_RUN)  ? (enable ? RD_RUN : RD_STOP) :
                  enable ? RD_RUN : (occ == 2'd0 && !infl) ? RD_IDLE : RD_STOP;
    end
  end
endmodule
